// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into 3x3 sliding windows.
// Two line buffers hold the previous two rows; a 3x3 shift array collects the
// current window column by column. Windows are registered and qualified by
// win_valid one clock after the bottom-right pixel is accepted.
module conv_window_gen #(
  parameter int IMAGE_SIZE  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  win_valid,
  output logic [ADDR_SIZE-1:0]  win_row,
  output logic [ADDR_SIZE-1:0]  win_col,
  output logic [DATA_WIDTH-1:0] ImgP1,
  output logic [DATA_WIDTH-1:0] ImgP2,
  output logic [DATA_WIDTH-1:0] ImgP3,
  output logic [DATA_WIDTH-1:0] ImgP4,
  output logic [DATA_WIDTH-1:0] ImgP5,
  output logic [DATA_WIDTH-1:0] ImgP6,
  output logic [DATA_WIDTH-1:0] ImgP7,
  output logic [DATA_WIDTH-1:0] ImgP8,
  output logic [DATA_WIDTH-1:0] ImgP9,
  output logic                  frame_done
);

  localparam int K = KERNEL_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(IMAGE_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] FIRST = ADDR_SIZE'(K - 1);

  typedef logic [IMAGE_SIZE-1:0][DATA_WIDTH-1:0] line_t;
  typedef logic [K-1:0][K-1:0][DATA_WIDTH-1:0]   win_t;  // [row][col]

  logic [ADDR_SIZE-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
  logic [ADDR_SIZE-1:0] cur_row, cur_col;
  line_t                lb0_q, lb0_d;  // row r-1
  line_t                lb1_q, lb1_d;  // row r-2
  win_t                 win_q, win_d;  // running shift array
  win_t                 out_q, out_d;  // registered window presented to conv_block
  logic                 vld_q, vld_d, done_q, done_d, emit;
  logic [ADDR_SIZE-1:0] wrow_q, wrow_d, wcol_q, wcol_d;

  // Position of the pixel on in_data; sof forces (0,0) and abandons any old frame.
  always_comb begin
    cur_row = in_sof ? '0 : in_row_q;
    cur_col = in_sof ? '0 : in_col_q;
    in_row_d = in_row_q;
    in_col_d = in_col_q;
    if (in_valid) begin
      if (cur_col == LAST) begin
        in_col_d = '0;
        in_row_d = (cur_row == LAST) ? '0 : cur_row + 1'b1;
      end else begin
        in_col_d = cur_col + 1'b1;
        in_row_d = cur_row;
      end
    end
  end

  // Line buffers and window shift: reads use the old contents (previous rows),
  // so a same-column write this cycle is never seen by this pixel's window.
  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    win_d = win_q;
    if (in_valid) begin
      lb1_d[cur_col] = lb0_q[cur_col];
      lb0_d[cur_col] = in_data;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K - 1; j++)
          win_d[i][j] = win_q[i][j+1];
      win_d[0][K-1] = lb1_q[cur_col];
      win_d[1][K-1] = lb0_q[cur_col];
      win_d[2][K-1] = in_data;
    end
  end

  // A window is complete once the accepted pixel is at least two rows and two
  // columns in; rows 0/1 of the current frame are always behind it, so stale
  // line-buffer data from an earlier frame cannot leak into it.
  always_comb begin
    emit   = in_valid && (cur_row >= FIRST) && (cur_col >= FIRST);
    vld_d  = emit;
    done_d = emit && (cur_row == LAST) && (cur_col == LAST);
    out_d  = emit ? win_d : out_q;
    wrow_d = emit ? cur_row - FIRST : wrow_q;
    wcol_d = emit ? cur_col - FIRST : wcol_q;
  end

  // All state registers; reset clears everything including the line buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_row_q <= '0;
      in_col_q <= '0;
      lb0_q    <= '0;
      lb1_q    <= '0;
      win_q    <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      wrow_q   <= '0;
      wcol_q   <= '0;
    end else begin
      in_row_q <= in_row_d;
      in_col_q <= in_col_d;
      lb0_q    <= lb0_d;
      lb1_q    <= lb1_d;
      win_q    <= win_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      wrow_q   <= wrow_d;
      wcol_q   <= wcol_d;
    end
  end

  assign win_valid  = vld_q;
  assign frame_done = done_q;
  assign win_row    = wrow_q;
  assign win_col    = wcol_q;
  assign ImgP1 = out_q[0][0];
  assign ImgP2 = out_q[0][1];
  assign ImgP3 = out_q[0][2];
  assign ImgP4 = out_q[1][0];
  assign ImgP5 = out_q[1][1];
  assign ImgP6 = out_q[1][2];
  assign ImgP7 = out_q[2][0];
  assign ImgP8 = out_q[2][1];
  assign ImgP9 = out_q[2][2];

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen (16x16 FP16 stream).
module tb_conv_window_gen;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof;
  logic [DW-1:0] in_data;
  logic win_valid, frame_done;
  logic [AW-1:0] win_row, win_col;
  logic [DW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;

  conv_window_gen #(.IMAGE_SIZE(N), .KERNEL_SIZE(3), .DATA_WIDTH(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .ImgP1(p1), .ImgP2(p2), .ImgP3(p3), .ImgP4(p4), .ImgP5(p5),
    .ImgP6(p6), .ImgP7(p7), .ImgP8(p8), .ImgP9(p9), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]        row;
    logic [AW-1:0]        col;
    logic                 fd;
    logic [8:0][DW-1:0]   p;    // p[0] = P1
    int                   cyc;  // cycle the window must appear on
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_win = 0, n_fd = 0, cyc = 0;
  bit prev_acc = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_acc <= in_valid && !rst;
  end

  // Window (r,c) of a ramp frame: pixel(y,x) = base + y*16 + x.
  function automatic exp_t mk(int base, int r, int c, int cy);
    exp_t e;
    e.row = AW'(r);
    e.col = AW'(c);
    e.fd  = (r == N - 3) && (c == N - 3);
    e.cyc = cy;
    for (int k = 0; k < 9; k++) e.p[k] = DW'(base + (r + k / 3) * 16 + (c + k % 3));
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a window is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid) begin
        exp_t e, a;
        n_win++;
        if (frame_done) n_fd++;
        a.row = win_row; a.col = win_col; a.fd = frame_done; a.cyc = cyc;
        a.p = {p9, p8, p7, p6, p5, p4, p3, p2, p1};
        n_chk++;
        if (!prev_acc) begin
          n_fail++;
          $display("FAIL gap_window: win_valid with no pixel accepted on the previous edge (cyc %0d)", cyc);
        end else if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_window: got row %0d col %0d P1 %h, scoreboard empty", win_row, win_col, p1);
        end else begin
          e = q.pop_front();
          if (a != e)
            begin
              n_fail++;
              $display("FAIL window: got r%0d c%0d fd%0b cyc%0d P=%h, expected r%0d c%0d fd%0b cyc%0d P=%h",
                       a.row, a.col, a.fd, a.cyc, a.p, e.row, e.col, e.fd, e.cyc, e.p);
            end
        end
      end else if (frame_done) begin
        n_chk++; n_fail++;
        $display("FAIL frame_done_alone: frame_done=1 without win_valid (cyc %0d)", cyc);
      end
    end
  end

  task automatic drive(bit v, bit sof, int base, int r, int c);
    @(posedge clk); #1;
    in_valid = v;
    in_sof   = sof;
    in_data  = DW'(base + r * 16 + c);
    if (v && r >= 2 && c >= 2) q.push_back(mk(base, r - 2, c - 2, cyc + 1));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  // Sends the first npix pixels of a ramp frame in raster order.
  task automatic send(int base, bit sof, bit gaps, int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) idle();
      drive(1'b1, sof && i == 0, base, i / N, i % N);
    end
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 8; i++) idle();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d windows never appeared, expected 0 outstanding", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_count(string name, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_zero(string name);
    @(negedge clk);
    n_chk++;
    if ({win_valid, frame_done, win_row, win_col, p1, p2, p3, p4, p5, p6, p7, p8, p9} != '0) begin
      n_fail++;
      $display("FAIL %s: outputs v%0b fd%0b r%0d c%0d P1 %h P9 %h, expected all zero",
               name, win_valid, frame_done, win_row, win_col, p1, p9);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, f0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    check_zero("reset_state");
    @(posedge clk); #1 rst = 1'b0;

    // T1: continuous ramp frame
    w0 = n_win; f0 = n_fd;
    send(0, 1'b0, 1'b0, N * N);
    drain("t1");
    check_count("t1_windows", n_win - w0, 196);
    check_count("t1_frame_done", n_fd - f0, 1);

    // T2: same frame with random idle gaps (sof re-aligns just in case)
    w0 = n_win; f0 = n_fd;
    send(0, 1'b1, 1'b1, N * N);
    drain("t2");
    check_count("t2_windows", n_win - w0, 196);
    check_count("t2_frame_done", n_fd - f0, 1);

    // T3: five rows of one frame, then a sof restart with a different frame
    w0 = n_win; f0 = n_fd;
    send(0, 1'b0, 1'b0, 5 * N);
    send(16'h8000, 1'b1, 1'b0, N * N);
    drain("t3");
    check_count("t3_windows", n_win - w0, 3 * 14 + 196);
    check_count("t3_frame_done", n_fd - f0, 1);

    // T4: two frames back to back, no sof, no idle
    w0 = n_win; f0 = n_fd;
    send(0, 1'b0, 1'b0, N * N);
    send(16'h4000, 1'b0, 1'b0, N * N);
    drain("t4");
    check_count("t4_windows", n_win - w0, 392);
    check_count("t4_frame_done", n_fd - f0, 2);

    // T5: reset while pixel (7,9) is offered, then a clean frame without sof
    send(0, 1'b0, 1'b0, 7 * N + 9);
    idle();
    idle();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_data = DW'(7 * 16 + 9);
    check_zero("t5_reset_clear");
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    w0 = n_win; f0 = n_fd;
    send(0, 1'b0, 1'b0, N * N);
    drain("t5");
    check_count("t5_windows", n_win - w0, 196);
    check_count("t5_frame_done", n_fd - f0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
